// File: rtl/ball_motion_ctrl.sv
// ----------------------------------------------------------------------------
// ball_motion_ctrl
//
// Moves the screensaver ball during vertical blank. A frame_tick starts a
// burst of `speed` steps. Each step moves X and Y by one pixel in the same
// clock. When the ball reaches a screen edge its direction reflects, so the
// position always stays on screen and never wraps. Every output is registered,
// so the pixel renderer only sees positions that change during vblank.
//
// Optional feature (macro BOUNCE_COLOR_EN):
//   Adds a 6-bit color output. The value is an LFSR that advances once for
//   each bounce pulse.
//
// Ports:
//   clk         in   system clock
//   rst_n       in   asynchronous active-low reset
//   frame_tick  in   one-cycle pulse at the start of vblank
//   pause       in   level; while high, frame_tick is ignored
//   speed       in   [2:0] steps per frame (0 = stationary)
//   ball_x      out  [POS_W-1:0] left edge of the ball
//   ball_y      out  [POS_W-1:0] top edge of the ball
//   dir_x       out  1 = moving right, 0 = moving left
//   dir_y       out  1 = moving down,  0 = moving up
//   busy        out  high while steps are being applied
//   frame_done  out  one-cycle pulse after the frame's last step
//   bounce      out  one-cycle pulse after any reflecting step
//   corner      out  one-cycle pulse after a step where both axes reflect
//   color       out  [5:0] bounce color (only with BOUNCE_COLOR_EN)
// ----------------------------------------------------------------------------
module ball_motion_ctrl #(
   parameter int H_RES     = 640,
   parameter int V_RES     = 480,
   parameter int BALL_SIZE = 32,
   parameter int POS_W     = 10
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             frame_tick,
   input  logic             pause,
   input  logic [2:0]       speed,
   output logic [POS_W-1:0] ball_x,
   output logic [POS_W-1:0] ball_y,
   output logic             dir_x,
   output logic             dir_y,
   output logic             busy,
   output logic             frame_done,
   output logic             bounce,
   output logic             corner
`ifdef BOUNCE_COLOR_EN
   ,
   output logic [5:0]       color
`endif
);

   localparam logic [POS_W-1:0] XMAX    = POS_W'(H_RES - BALL_SIZE);
   localparam logic [POS_W-1:0] YMAX    = POS_W'(V_RES - BALL_SIZE);
   localparam logic [POS_W-1:0] POS_ONE = POS_W'(1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MOVE = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t     state_reg;
   logic [2:0] cnt_reg;

   // Next-step values for both axes.
   logic             x_hit, y_hit;
   logic             x_fwd, y_fwd;
   logic [POS_W-1:0] x_next, y_next;

   // A reflection at an edge only inverts the direction of this step. At XMAX
   // the ball steps back to XMAX-1, and at 0 it steps to 1. Both cases are
   // a normal +/-1 step in the inverted direction, so one adder per axis
   // covers both cases.
   always_comb begin
      x_hit  = dir_x ? (ball_x == XMAX) : (ball_x == '0);
      y_hit  = dir_y ? (ball_y == YMAX) : (ball_y == '0);
      x_fwd  = dir_x ^ x_hit;
      y_fwd  = dir_y ^ y_hit;
      x_next = x_fwd ? (ball_x + POS_ONE) : (ball_x - POS_ONE);
      y_next = y_fwd ? (ball_y + POS_ONE) : (ball_y - POS_ONE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg  <= IDLE;
         cnt_reg    <= 3'd0;
         ball_x     <= '0;
         ball_y     <= '0;
         dir_x      <= 1'b1;
         dir_y      <= 1'b1;
         busy       <= 1'b0;
         frame_done <= 1'b0;
         bounce     <= 1'b0;
         corner     <= 1'b0;
`ifdef BOUNCE_COLOR_EN
         color      <= 6'b111111;
`endif
      end else begin
         frame_done <= 1'b0;
         bounce     <= 1'b0;
         corner     <= 1'b0;
`ifdef BOUNCE_COLOR_EN
         // bounce is a single pulse even for a corner. This makes the
         // color advance only once per reflecting step.
         if (bounce) begin
            color <= {color[4:0], color[5] ^ color[4]};
         end
`endif
         case (state_reg)
            IDLE: begin
               if (frame_tick && !pause) begin
                  if (speed != 3'd0) begin
                     cnt_reg   <= speed;
                     busy      <= 1'b1;
                     state_reg <= MOVE;
                  end else begin
                     state_reg <= DONE;
                  end
               end
            end

            MOVE: begin
               ball_x  <= x_next;
               ball_y  <= y_next;
               dir_x   <= x_fwd;
               dir_y   <= y_fwd;
               bounce  <= x_hit | y_hit;
               corner  <= x_hit & y_hit;
               cnt_reg <= cnt_reg - 3'd1;
               if (cnt_reg == 3'd1) begin
                  busy      <= 1'b0;
                  state_reg <= DONE;
               end
            end

            DONE: begin
               frame_done <= 1'b1;
               state_reg  <= IDLE;
            end

            default: begin
               busy      <= 1'b0;
               state_reg <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ball_motion_ctrl.sv
// ----------------------------------------------------------------------------
// tb_ball_motion_ctrl
//
// Directed testbench for ball_motion_ctrl. The bench drives the inputs and
// samples the outputs on the falling clock edge. It compares the outputs
// against values worked out by hand for the default 640x480 screen with a
// 32-pixel ball (XMAX = 608, YMAX = 448).
// ----------------------------------------------------------------------------
module tb_ball_motion_ctrl;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       frame_tick = 1'b0;
   logic       pause = 1'b0;
   logic [2:0] speed = 3'd0;
   logic [9:0] ball_x, ball_y;
   logic       dir_x, dir_y, busy, frame_done, bounce, corner;
`ifdef BOUNCE_COLOR_EN
   logic [5:0] color;
`endif

   int tests  = 0;
   int failed = 0;

   ball_motion_ctrl dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .frame_tick (frame_tick),
      .pause      (pause),
      .speed      (speed),
      .ball_x     (ball_x),
      .ball_y     (ball_y),
      .dir_x      (dir_x),
      .dir_y      (dir_y),
      .busy       (busy),
      .frame_done (frame_done),
      .bounce     (bounce),
      .corner     (corner)
`ifdef BOUNCE_COLOR_EN
      ,
      .color      (color)
`endif
   );

   always #5 clk = ~clk;

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      frame_tick = 1'b0;
      pause = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   // One frame: pulse the tick, then watch until frame_done (bounded wait).
   task automatic run_frame(input int spd, output int busy_c, output int lat,
                            output int bnc, output int crn, output int both);
      busy_c = 0; lat = 0; bnc = 0; crn = 0; both = 0;
      @(negedge clk);
      speed = spd[2:0];
      frame_tick = 1'b1;
      for (int i = 1; i <= 30; i++) begin
         @(negedge clk);
         frame_tick = 1'b0;
         if (busy) busy_c++;
         if (bounce) bnc++;
         if (corner) crn++;
         if (bounce && corner) both++;
         if (frame_done) begin
            lat = i;
            break;
         end
      end
      if (lat == 0) begin
         tests++; failed++;
         $display("FAIL frame_timeout: got no frame_done within 30 cycles, expected one (speed %0d)", spd);
      end
   endtask

   task automatic run_frames(input int n, input int spd);
      int b, l, bn, c, bo;
      for (int k = 0; k < n; k++) run_frame(spd, b, l, bn, c, bo);
   endtask

   task automatic test_reset();
      do_reset();
      tests++; if (ball_x !== 10'd0) begin failed++; $display("FAIL reset_x: got %0d expected 0", ball_x); end
      tests++; if (ball_y !== 10'd0) begin failed++; $display("FAIL reset_y: got %0d expected 0", ball_y); end
      tests++; if ({dir_x, dir_y} !== 2'b11) begin failed++; $display("FAIL reset_dir: got %b expected 11", {dir_x, dir_y}); end
      tests++; if ({busy, frame_done, bounce, corner} !== 4'b0000) begin failed++; $display("FAIL reset_flags: got %b expected 0000", {busy, frame_done, bounce, corner}); end
`ifdef BOUNCE_COLOR_EN
      tests++; if (color !== 6'b111111) begin failed++; $display("FAIL reset_color: got %b expected 111111", color); end
`endif
   endtask

   task automatic test_single_step();
      int b, l, bn, c, bo;
      do_reset();
      run_frame(1, b, l, bn, c, bo);
      tests++; if (l !== 3) begin failed++; $display("FAIL single_latency: got %0d expected 3", l); end
      tests++; if (ball_x !== 10'd1 || ball_y !== 10'd1) begin failed++; $display("FAIL single_pos: got (%0d,%0d) expected (1,1)", ball_x, ball_y); end
      tests++; if (bn !== 0) begin failed++; $display("FAIL single_bounce: got %0d pulses expected 0", bn); end
      tests++; if (b !== 1) begin failed++; $display("FAIL single_busy: got %0d cycles expected 1", b); end
   endtask

   task automatic test_speed_zero();
      int b, l, bn, c, bo;
      run_frame(0, b, l, bn, c, bo);
      tests++; if (l !== 2) begin failed++; $display("FAIL zero_latency: got %0d expected 2", l); end
      tests++; if (b !== 0) begin failed++; $display("FAIL zero_busy: got %0d cycles expected 0", b); end
      tests++; if (ball_x !== 10'd1 || ball_y !== 10'd1) begin failed++; $display("FAIL zero_pos: got (%0d,%0d) expected (1,1)", ball_x, ball_y); end
   endtask

   task automatic test_multi_frame();
      int b, l, bn, c, bo, bad;
      bad = 0;
      do_reset();
      for (int k = 0; k < 10; k++) begin
         run_frame(7, b, l, bn, c, bo);
         if (b != 7 || l != 9) bad++;
         repeat (20 - l) @(negedge clk);
      end
      tests++; if (bad !== 0) begin failed++; $display("FAIL multi_busy: got %0d bad frames expected 0", bad); end
      tests++; if (ball_x !== 10'd70 || ball_y !== 10'd70) begin failed++; $display("FAIL multi_pos: got (%0d,%0d) expected (70,70)", ball_x, ball_y); end
   endtask

   task automatic test_right_edge();
      int waited;
      do_reset();
      run_frames(86, 7);
      run_frames(1, 6);
      tests++; if (ball_x !== 10'd608 || ball_y !== 10'd288) begin failed++; $display("FAIL edge_setup: got (%0d,%0d) expected (608,288)", ball_x, ball_y); end
      tests++; if ({dir_x, dir_y} !== 2'b10) begin failed++; $display("FAIL edge_setup_dir: got %b expected 10", {dir_x, dir_y}); end
`ifdef BOUNCE_COLOR_EN
      tests++; if (color !== 6'b111110) begin failed++; $display("FAIL color_first: got %b expected 111110", color); end
`endif
      @(negedge clk); speed = 3'd3; frame_tick = 1'b1;
      @(negedge clk); frame_tick = 1'b0;
      @(negedge clk);
      tests++; if (ball_x !== 10'd607) begin failed++; $display("FAIL edge_x1: got %0d expected 607", ball_x); end
      tests++; if (dir_x !== 1'b0) begin failed++; $display("FAIL edge_dir: got %b expected 0", dir_x); end
      tests++; if ({bounce, corner} !== 2'b10) begin failed++; $display("FAIL edge_pulse: got %b expected 10", {bounce, corner}); end
      @(negedge clk);
      tests++; if (ball_x !== 10'd606 || bounce !== 1'b0) begin failed++; $display("FAIL edge_x2: got x=%0d bounce=%b expected x=606 bounce=0", ball_x, bounce); end
      @(negedge clk);
      tests++; if (ball_x !== 10'd605 || ball_y !== 10'd285) begin failed++; $display("FAIL edge_x3: got (%0d,%0d) expected (605,285)", ball_x, ball_y); end
      waited = 0;
      while (!frame_done && waited < 10) begin @(negedge clk); waited++; end
      tests++; if (frame_done !== 1'b1) begin failed++; $display("FAIL edge_done: got %b expected 1", frame_done); end
`ifdef BOUNCE_COLOR_EN
      tests++; if (color !== 6'b111100) begin failed++; $display("FAIL color_second: got %b expected 111100", color); end
`endif
   endtask

   task automatic test_corner();
      int b, l, bn, c, bo;
      do_reset();
      run_frames(2432, 7);   // 17024 steps = lcm(2*608, 2*448)
      tests++; if (ball_x !== 10'd0 || ball_y !== 10'd0 || {dir_x, dir_y} !== 2'b00) begin failed++; $display("FAIL corner_setup: got (%0d,%0d) dir %b expected (0,0) dir 00", ball_x, ball_y, {dir_x, dir_y}); end
      run_frame(1, b, l, bn, c, bo);
      tests++; if (ball_x !== 10'd1 || ball_y !== 10'd1) begin failed++; $display("FAIL corner_pos: got (%0d,%0d) expected (1,1)", ball_x, ball_y); end
      tests++; if ({dir_x, dir_y} !== 2'b11) begin failed++; $display("FAIL corner_dir: got %b expected 11", {dir_x, dir_y}); end
      tests++; if (bo !== 1 || bn !== 1) begin failed++; $display("FAIL corner_pulse: got both=%0d bounce=%0d expected 1 and 1", bo, bn); end
   endtask

   task automatic test_pause_and_ignore();
      int busy_seen, fd_seen, busy_c, x0;
      do_reset();
      x0 = ball_x;
      busy_seen = 0; fd_seen = 0;
      pause = 1'b1; speed = 3'd7;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk); frame_tick = 1'b1;
         @(negedge clk); frame_tick = 1'b0;
         for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            if (busy) busy_seen++;
            if (frame_done) fd_seen++;
         end
      end
      tests++; if (busy_seen !== 0 || fd_seen !== 0) begin failed++; $display("FAIL pause_busy: got busy=%0d done=%0d expected 0 and 0", busy_seen, fd_seen); end
      tests++; if (ball_x !== x0[9:0]) begin failed++; $display("FAIL pause_pos: got %0d expected %0d", ball_x, x0); end
      pause = 1'b0;
      busy_c = 0; fd_seen = 0;
      @(negedge clk); frame_tick = 1'b1;
      for (int i = 1; i <= 25; i++) begin
         @(negedge clk);
         frame_tick = (i == 3);
         if (i == 3) begin speed = 3'd1; pause = 1'b1; end
         if (i == 4) pause = 1'b0;
         if (busy) busy_c++;
         if (frame_done) fd_seen++;
      end
      tests++; if (busy_c !== 7) begin failed++; $display("FAIL ignore_busy: got %0d cycles expected 7", busy_c); end
      tests++; if (fd_seen !== 1) begin failed++; $display("FAIL ignore_done: got %0d pulses expected 1", fd_seen); end
      tests++; if (ball_x !== 10'd7 || ball_y !== 10'd7) begin failed++; $display("FAIL ignore_pos: got (%0d,%0d) expected (7,7)", ball_x, ball_y); end
   endtask

   task automatic test_reset_mid_move();
      int b, l, bn, c, bo, fd_seen, busy_seen;
      do_reset();
      run_frame(7, b, l, bn, c, bo);
      @(negedge clk); speed = 3'd7; frame_tick = 1'b1;
      @(negedge clk); frame_tick = 1'b0;
      @(negedge clk);
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      tests++; if (ball_x !== 10'd0 || ball_y !== 10'd0) begin failed++; $display("FAIL abort_pos: got (%0d,%0d) expected (0,0)", ball_x, ball_y); end
      tests++; if ({dir_x, dir_y, busy, frame_done, bounce, corner} !== 6'b110000) begin failed++; $display("FAIL abort_flags: got %b expected 110000", {dir_x, dir_y, busy, frame_done, bounce, corner}); end
`ifdef BOUNCE_COLOR_EN
      tests++; if (color !== 6'b111111) begin failed++; $display("FAIL abort_color: got %b expected 111111", color); end
`endif
      fd_seen = 0; busy_seen = 0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (frame_done) fd_seen++;
         if (busy) busy_seen++;
      end
      tests++; if (fd_seen !== 0 || busy_seen !== 0) begin failed++; $display("FAIL abort_done: got done=%0d busy=%0d expected 0 and 0", fd_seen, busy_seen); end
   endtask

   initial begin
      test_reset();
      test_single_step();
      test_speed_zero();
      test_multi_frame();
      test_right_edge();
      test_corner();
      test_pause_and_ignore();
      test_reset_mid_move();
      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
